mdu: RTL and testbench
======================

Name: mdu

Overview:
- Parametrised multiply/divide unit with HI/LO registers for the pipelined MIPS core; sits beside the ALU in the EX stage.
- Supports signed and unsigned multiply and divide, plus direct HI/LO writes.
- Multiply and divide are multi-cycle, with configurable fixed latency and a busy indication the hazard unit uses to stall mfhi/mflo/mult-class instructions.
- Supports abort, so an exception flush can cancel an in-flight operation.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MULT_CYCLES, 5, cycles from accepted mult/multu to HI/LO commit; must be >= 1.
- DIV_CYCLES, 10, cycles from accepted div/divu to HI/LO commit; must be >= 1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  request: execute op on A/B this cycle.
- op  in  3  operation code (see package).
- A  in  WIDTH  rs operand / dividend / mthi-mtlo source.
- B  in  WIDTH  rt operand / divisor.
- abort  in  1  cancel in-flight operation (exception flush).
- busy  out  1  operation in progress; HI/LO not yet updated.
- HI  out  WIDTH  HI register.
- LO  out  WIDTH  LO register.

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high.
- Reset: HI=0, LO=0, busy=0, counter=0, pending op=NONE. Reset mid-operation discards the result.
- Idle acceptance: start is honoured only when busy=0 and abort=0. start while busy=1 is ignored; the hazard unit guarantees the op is re-presented.
- MTHI/MTLO: HI (or LO) <= A at the accepting edge. busy stays 0. No latency.
- MULT/MULTU/DIV/DIVU: at the accepting edge (edge k), operands are latched and the result is computed into internal result registers. Counter loads N = MULT_CYCLES or DIV_CYCLES, and busy goes 1.
- Counting: counter decrements each edge. At edge k+N, HI/LO take the result, busy returns to 0, and counter reaches 0. busy is therefore high for exactly N cycles.
- HI/LO hold their old values while busy=1.
- Back-to-back: a new start is accepted in the first cycle busy=0, i.e. the cycle after the commit edge.
- MULT: {HI,LO} = signed A x signed B, full 2*WIDTH product. MULTU: same, unsigned.
- DIV: LO = quotient truncated toward zero, HI = remainder with the sign of the dividend.
  - Special case: A = most-negative value and B = -1 gives LO = A, HI = 0.
- DIVU: unsigned quotient/remainder.
- Divide by zero (DIV or DIVU with B=0): the operation runs its full latency, busy behaves normally, and HI/LO are left unchanged at commit.
- abort=1: counter is cleared, busy goes 0 at the next edge, and the pending result is discarded; HI/LO are unchanged.
  - abort together with start in the same cycle: start is ignored, including MTHI/MTLO.
  - abort on the commit edge: abort wins and no commit occurs.
- op=NONE or an undefined code with start=1: no effect.
- Outputs are registered; there is no combinational path from inputs to HI/LO/busy.

Decomposition:
- Shared package/header mdu_defs:
  - MDU_OP_W = 3.
  - Op codes: MDU_NONE=0, MDU_MULT=1, MDU_MULTU=2, MDU_DIV=3, MDU_DIVU=4, MDU_MTHI=5, MDU_MTLO=6.
  - Default latency constants.
- Core decoder uses these constants to drive op.
- No sub-module required; arithmetic is single-step combinational on the latched operands, delayed by a down-counter.
- A later iterative divider would slot in as mdu_div without changing the port list.

Test Plan:
- Reset then idle: HI=0, LO=0, busy=0. Assert reset mid-MULT: all outputs 0 immediately, no later commit.
- MULT A=0xFFFFFFFE (-2), B=3, MULT_CYCLES=5 -> busy high for exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU on the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- DIV A=-7 (0xFFFFFFF9), B=2 -> after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU A=7, B=2 -> LO=3, HI=1. DIV A=0x80000000, B=-1 -> LO=0x80000000, HI=0.
- Divide by zero: preload HI=0x11 and LO=0x22 via MTHI/MTLO, then DIV A=5, B=0 -> busy for 10 cycles, HI=0x11, LO=0x22 after.
- start while busy: a MTHI A=0x55 issued in cycle 2 of a MULT is ignored, and HI equals the MULT result. A back-to-back start in the first idle cycle is accepted.
- abort at cycle 3 of a DIV: busy=0 next cycle, HI/LO unchanged. abort with start=1, op=MTLO, A=0x99 -> LO unchanged.

Source files
------------

// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared op codes and default latencies for the multiply/divide unit
//
// Purpose: single source of the MDU op encoding and default latency values,
//          imported by the MDU core and by any decoder that drives its op port.
// Contents: MDU_OP_W, mdu_op_e op codes, default latency localparams.

package mdu_pkg;

  localparam int MDU_OP_W = 3;

  typedef enum logic [MDU_OP_W-1:0] {
    MDU_NONE  = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4,
    MDU_MTHI  = 3'd5,
    MDU_MTLO  = 3'd6
  } mdu_op_e;

  localparam int MDU_MULT_CYCLES = 5;
  localparam int MDU_DIV_CYCLES  = 10;

endpackage

// File: rtl/mdu.sv
// rtl/mdu.sv - multi-cycle multiply/divide unit with HI/LO registers
//
// Purpose: EX-stage MDU. mult/multu/div/divu compute their result at the
//          accepting edge into hidden result registers; a down-counter then
//          holds busy high for a fixed latency before HI/LO commit.
//          mthi/mtlo write immediately. abort cancels any in-flight op.
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   asynchronous active-high reset
//   start  in   execute op on A/B this cycle (honoured only when idle, no abort)
//   op     in   operation code (mdu_op_e)
//   A      in   rs operand / dividend / mthi-mtlo source
//   B      in   rt operand / divisor
//   abort  in   cancel in-flight operation
//   busy   out  operation in progress, HI/LO not yet updated
//   HI     out  HI register
//   LO     out  LO register

module mdu
  import mdu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = MDU_MULT_CYCLES,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [MDU_OP_W-1:0] op,
  input  logic [WIDTH-1:0]    A,
  input  logic [WIDTH-1:0]    B,
  input  logic                abort,
  output logic                busy,
  output logic [WIDTH-1:0]    HI,
  output logic [WIDTH-1:0]    LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_e;

  state_e           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic [WIDTH-1:0] res_hi, res_lo;
  logic             res_wr;

  mdu_op_e          op_dec;
  logic             load_res, commit, ld_hi, ld_lo;

  logic [WIDTH-1:0] ar_hi, ar_lo;
  logic             ar_wr;

  logic signed [2*WIDTH-1:0] s_a, s_b, s_prod;
  logic        [2*WIDTH-1:0] u_prod;
  logic signed [WIDTH-1:0]   s_dvd, s_dvs, s_quo, s_rem;
  logic        [WIDTH-1:0]   u_dvs, u_quo, u_rem;

  assign op_dec = mdu_op_e'(op);

  // Divisors are sanitised so the dividers never see 0, and so the signed
  // overflow case (MOST_NEG / -1) becomes MOST_NEG / 1, which already yields
  // the architected LO = A, HI = 0.
  always_comb begin
    s_a    = {{WIDTH{A[WIDTH-1]}}, A};
    s_b    = {{WIDTH{B[WIDTH-1]}}, B};
    s_prod = s_a * s_b;
    u_prod = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};

    s_dvd  = A;
    s_dvs  = ((B == '0) || (A == MOST_NEG && B == '1)) ? ONE : B;
    s_quo  = s_dvd / s_dvs;
    s_rem  = s_dvd % s_dvs;

    u_dvs  = (B == '0) ? ONE : B;
    u_quo  = A / u_dvs;
    u_rem  = A % u_dvs;
  end

  // Result and its write-enable; divide by zero keeps ar_wr low so the
  // commit leaves HI/LO untouched.
  always_comb begin
    ar_hi = '0;
    ar_lo = '0;
    ar_wr = 1'b0;
    case (op_dec)
      MDU_MULT:  begin ar_hi = s_prod[2*WIDTH-1:WIDTH]; ar_lo = s_prod[WIDTH-1:0]; ar_wr = 1'b1; end
      MDU_MULTU: begin ar_hi = u_prod[2*WIDTH-1:WIDTH]; ar_lo = u_prod[WIDTH-1:0]; ar_wr = 1'b1; end
      MDU_DIV:   begin ar_hi = s_rem; ar_lo = s_quo; ar_wr = (B != '0); end
      MDU_DIVU:  begin ar_hi = u_rem; ar_lo = u_quo; ar_wr = (B != '0); end
      default:   ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    load_res  = 1'b0;
    commit    = 1'b0;
    ld_hi     = 1'b0;
    ld_lo     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && !abort) begin
          case (op_dec)
            MDU_MULT, MDU_MULTU: begin
              state_nxt = ST_RUN;
              cnt_nxt   = CW'(MULT_CYCLES);
              load_res  = 1'b1;
            end
            MDU_DIV, MDU_DIVU: begin
              state_nxt = ST_RUN;
              cnt_nxt   = CW'(DIV_CYCLES);
              load_res  = 1'b1;
            end
            MDU_MTHI: ld_hi = 1'b1;
            MDU_MTLO: ld_lo = 1'b1;
            default:  ;
          endcase
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CW'(1)) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
          commit    = 1'b1;
        end else begin
          cnt_nxt   = cnt - CW'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      res_hi <= '0;
      res_lo <= '0;
      res_wr <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (load_res) begin
        res_hi <= ar_hi;
        res_lo <= ar_lo;
        res_wr <= ar_wr;
      end
      if (commit && res_wr) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end
      if (ld_hi) hi_q <= A;
      if (ld_lo) lo_q <= A;
    end
  end

  assign busy = (state == ST_RUN);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// tb/tb_mdu.sv - self-checking bench for the multiply/divide unit
module tb_mdu;

  localparam int W  = 32;
  localparam int MC = 5;
  localparam int DC = 10;

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] A, B;
  logic         abort;
  logic         busy;
  logic [W-1:0] HI, LO;

  int           checks   = 0;
  int           failures = 0;
  logic [31:0]  exp_hi   = '0;
  logic [31:0]  exp_lo   = '0;

  mdu #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .A     (A),
    .B     (B),
    .abort (abort),
    .busy  (busy),
    .HI    (HI),
    .LO    (LO)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int op_lat(input logic [2:0] o);
    if (o == OP_MULT || o == OP_MULTU) return MC;
    if (o == OP_DIV  || o == OP_DIVU)  return DC;
    return 0;
  endfunction

  // Architectural model: full-width products and sign-magnitude division.
  function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] p;
    logic [31:0] ma, mb, q, r;
    case (o)
      OP_MULT: begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = 64'(sa * sb);
        exp_hi = p[63:32];
        exp_lo = p[31:0];
      end
      OP_MULTU: begin
        p  = {32'b0, a} * {32'b0, b};
        exp_hi = p[63:32];
        exp_lo = p[31:0];
      end
      OP_DIV: begin
        if (b != 0) begin
          ma = a[31] ? -a : a;
          mb = b[31] ? -b : b;
          q  = ma / mb;
          r  = ma % mb;
          if (a[31] ^ b[31]) q = -q;
          if (a[31]) r = -r;
          exp_lo = q;
          exp_hi = r;
        end
      end
      OP_DIVU: begin
        if (b != 0) begin
          exp_lo = a / b;
          exp_hi = a % b;
        end
      end
      OP_MTHI: exp_hi = a;
      OP_MTLO: exp_lo = a;
      default: ;
    endcase
  endfunction

  // Called at a negedge with the unit idle; returns at a negedge after commit.
  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input string tag);
    int lat;
    lat   = op_lat(o);
    start = 1'b1; op = o; A = a; B = b;
    @(negedge clk);
    start = 1'b0; op = OP_NONE;
    for (int i = 1; i <= lat; i++) begin
      chk({tag, " busy"}, {63'b0, busy}, 64'd1);
      chk({tag, " hold"}, {HI, LO}, {exp_hi, exp_lo});
      @(negedge clk);
    end
    model(o, a, b);
    chk({tag, " idle"}, {63'b0, busy}, 64'd0);
    chk({tag, " HI"}, {32'b0, HI}, {32'b0, exp_hi});
    chk({tag, " LO"}, {32'b0, LO}, {32'b0, exp_lo});
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    int          sel;

    reset = 1'b1; start = 1'b0; op = OP_NONE; A = '0; B = '0; abort = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset HI", {32'b0, HI}, 64'd0);
    chk("reset LO", {32'b0, LO}, 64'd0);
    chk("reset busy", {63'b0, busy}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    do_op(OP_MULT,  32'hFFFF_FFFE, 32'd3, "mult");
    chk("mult HI const", {32'b0, HI}, 64'hFFFF_FFFF);
    chk("mult LO const", {32'b0, LO}, 64'hFFFF_FFFA);
    do_op(OP_MULTU, 32'hFFFF_FFFE, 32'd3, "multu");
    chk("multu HI const", {32'b0, HI}, 64'h2);
    do_op(OP_DIV,   32'hFFFF_FFF9, 32'd2, "div");
    chk("div LO const", {32'b0, LO}, 64'hFFFF_FFFD);
    chk("div HI const", {32'b0, HI}, 64'hFFFF_FFFF);
    do_op(OP_DIVU,  32'd7, 32'd2, "divu");
    do_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, "div ovf");
    chk("div ovf LO const", {32'b0, LO}, 64'h8000_0000);

    do_op(OP_MTHI, 32'h11, 32'd0, "mthi");
    do_op(OP_MTLO, 32'h22, 32'd0, "mtlo");
    do_op(OP_DIV,  32'd5,  32'd0, "div0");
    chk("div0 HI const", {32'b0, HI}, 64'h11);
    chk("div0 LO const", {32'b0, LO}, 64'h22);

    // mthi during cycle 2 of a mult is ignored
    start = 1'b1; op = OP_MULT; A = 32'd1234; B = 32'hFFFF_0001;
    @(negedge clk); start = 1'b0;
    @(negedge clk); start = 1'b1; op = OP_MTHI; A = 32'h55;
    @(negedge clk); start = 1'b0; op = OP_NONE;
    repeat (3) @(negedge clk);
    model(OP_MULT, 32'd1234, 32'hFFFF_0001);
    chk("busy-start idle", {63'b0, busy}, 64'd0);
    chk("busy-start HI", {32'b0, HI}, {32'b0, exp_hi});
    chk("busy-start LO", {32'b0, LO}, {32'b0, exp_lo});
    do_op(OP_DIVU, 32'd1000, 32'd7, "back2back");

    // abort in cycle 3 of a div
    start = 1'b1; op = OP_DIV; A = 32'd99; B = 32'd4;
    @(negedge clk); start = 1'b0; op = OP_NONE;
    @(negedge clk);
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("abort busy", {63'b0, busy}, 64'd0);
    repeat (12) @(negedge clk);
    chk("abort HI", {32'b0, HI}, {32'b0, exp_hi});
    chk("abort LO", {32'b0, LO}, {32'b0, exp_lo});

    // abort together with start
    abort = 1'b1; start = 1'b1; op = OP_MTLO; A = 32'h99;
    @(negedge clk);
    op = OP_MULT; A = 32'd3; B = 32'd3;
    @(negedge clk);
    abort = 1'b0; start = 1'b0; op = OP_NONE;
    chk("abort+start LO", {32'b0, LO}, {32'b0, exp_lo});
    chk("abort+start busy", {63'b0, busy}, 64'd0);

    // abort on the commit edge
    start = 1'b1; op = OP_MULT; A = 32'd77; B = 32'd77;
    @(negedge clk); start = 1'b0; op = OP_NONE;
    repeat (4) @(negedge clk);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("abort commit busy", {63'b0, busy}, 64'd0);
    chk("abort commit HI/LO", {HI, LO}, {exp_hi, exp_lo});

    // NONE and undefined codes do nothing
    start = 1'b1; op = OP_NONE; A = 32'hDEAD; B = 32'd1;
    @(negedge clk); op = 3'd7;
    @(negedge clk); start = 1'b0; op = OP_NONE;
    chk("none busy", {63'b0, busy}, 64'd0);
    chk("none HI/LO", {HI, LO}, {exp_hi, exp_lo});

    // randomized ops against the model
    for (int n = 0; n < 30; n++) begin
      ro  = 3'($urandom_range(1, 6));
      ra  = $urandom;
      rb  = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) rb = '0;
      else if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      else if (sel == 2) rb = 32'($urandom_range(1, 20));
      do_op(ro, ra, rb, "rand");
    end

    // reset in the middle of a mult
    start = 1'b1; op = OP_MULT; A = 32'd12345; B = 32'd6789;
    @(negedge clk); start = 1'b0; op = OP_NONE;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midreset HI", {32'b0, HI}, 64'd0);
    chk("midreset LO", {32'b0, LO}, 64'd0);
    chk("midreset busy", {63'b0, busy}, 64'd0);
    @(negedge clk); reset = 1'b0;
    exp_hi = '0; exp_lo = '0;
    repeat (8) @(negedge clk);
    chk("post-reset HI/LO", {HI, LO}, 64'd0);
    chk("post-reset busy", {63'b0, busy}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
